// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder: keeps a running total in carry-save form and
// resolves it with one carry-propagate add when a packet's last beat arrives.
module csa_stream_accumulator #(
    parameter int WIDTH = 64,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_terms,
    input  logic [LANES-1:0]       in_mask,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_sat
);

    localparam int NOPS   = LANES + 2;
    localparam int POP_W  = $clog2(LANES + 1);
    localparam int CSUM_W = CNT_W + POP_W + 1;

    localparam logic [1:0] ST_ACC = 2'd0;
    localparam logic [1:0] ST_RES = 2'd1;
    localparam logic [1:0] ST_OUT = 2'd2;

    localparam logic [CSUM_W-1:0] CNT_MAX = {{(POP_W + 1){1'b0}}, {CNT_W{1'b1}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;

    logic [WIDTH-1:0]  tree_s;
    logic [WIDTH-1:0]  tree_c;
    logic [CSUM_W-1:0] cnt_sum;

    // Level-by-level 3:2 reduction of {S, C<<1, lanes}. The final level always
    // compresses exactly three operands, so its unshifted majority becomes the new C.
    always_comb begin : csa_tree
        logic [WIDTH-1:0] ops [NOPS];
        logic [WIDTH-1:0] nxt [NOPS];
        int n_cur;
        int n_nxt;

        ops[0] = s_q;
        ops[1] = c_q << 1;
        for (int k = 0; k < LANES; k++) begin
            ops[k + 2] = in_mask[k] ? in_terms[k*WIDTH +: WIDTH] : '0;
        end
        tree_s = '0;
        tree_c = '0;
        n_cur  = NOPS;
        n_nxt  = 0;

        for (int lvl = 0; lvl < NOPS; lvl++) begin
            if (n_cur > 2) begin
                n_nxt = 0;
                for (int i = 0; i < NOPS; i++) begin
                    nxt[i] = '0;
                end
                for (int g = 0; g < NOPS / 3; g++) begin
                    if (3 * g + 2 < n_cur) begin
                        nxt[n_nxt]     = ops[3*g] ^ ops[3*g+1] ^ ops[3*g+2];
                        nxt[n_nxt + 1] = ((ops[3*g] & ops[3*g+1]) | (ops[3*g] & ops[3*g+2])
                                         | (ops[3*g+1] & ops[3*g+2])) << 1;
                        if (n_cur == 3) begin
                            tree_s = ops[0] ^ ops[1] ^ ops[2];
                            tree_c = (ops[0] & ops[1]) | (ops[0] & ops[2]) | (ops[1] & ops[2]);
                        end
                        n_nxt = n_nxt + 2;
                    end
                end
                for (int i = 0; i < NOPS; i++) begin
                    if (i >= 3 * (n_cur / 3) && i < n_cur) begin
                        nxt[n_nxt] = ops[i];
                        n_nxt      = n_nxt + 1;
                    end
                end
                ops   = nxt;
                n_cur = n_nxt;
            end
        end
    end

    always_comb begin
        cnt_sum = CSUM_W'(count_q);
        for (int k = 0; k < LANES; k++) begin
            cnt_sum = cnt_sum + CSUM_W'(in_mask[k]);
        end
    end

    // NOTE: every next-state value is defaulted to its current value first, so no
    // path through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        count_d     = count_q;
        sat_d       = sat_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    s_d = tree_s;
                    c_d = tree_c;
                    if (cnt_sum >= CNT_MAX) begin
                        count_d = '1;
                        sat_d   = 1'b1;
                    end else begin
                        count_d = cnt_sum[CNT_W-1:0];
                    end
                    if (in_last) begin
                        state_d = ST_RES;
                    end
                end
            end
            ST_RES: begin
                out_sum_d   = s_q + (c_q << 1);
                out_count_d = count_q;
                out_sat_d   = sat_q;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_ACC;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed and randomized checks of csa_stream_accumulator; a second instance
// with a 4-bit term counter exercises count saturation.
module tb_csa_stream_accumulator;

    logic         clk = 1'b0;
    logic         clr;
    logic         in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
    logic [255:0] in_terms;
    logic [3:0]   in_mask;
    logic [63:0]  out_sum;
    logic [15:0]  out_count;

    logic         s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_sat;
    logic [255:0] s_in_terms;
    logic [3:0]   s_in_mask;
    logic [63:0]  s_out_sum;
    logic [3:0]   s_out_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_stream_accumulator #(.WIDTH(64), .LANES(4), .CNT_W(16)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_terms(in_terms), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_sat(out_sat)
    );

    csa_stream_accumulator #(.WIDTH(64), .LANES(4), .CNT_W(4)) dut_sat (
        .clk(clk), .clr(clr), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_terms(s_in_terms), .in_mask(s_in_mask), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
        .out_count(s_out_count), .out_sat(s_out_sat)
    );

    function automatic logic [255:0] pack4(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c, input logic [63:0] d);
        return {d, c, b, a};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [255:0] t, input logic [3:0] m, input logic l);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_terms = t;
        in_mask  = m;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_mask  = 4'h0;
    endtask

    task automatic take_result(input string name, input logic [63:0] exp_sum,
                               input int exp_cnt, input int hold);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_valid: out_valid=%b expected 1", name, out_valid);
        end
        total++;
        if (out_sum !== exp_sum) begin
            bad++;
            $display("FAIL %s_sum: got %h expected %h", name, out_sum, exp_sum);
        end
        total++;
        if (out_count !== 16'(exp_cnt) || out_sat !== 1'b0) begin
            bad++;
            $display("FAIL %s_count: got %0d sat=%b expected %0d sat=0", name, out_count, out_sat, exp_cnt);
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 64'd0 || out_count !== 16'd0 || out_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h count=%0d sat=%b expected 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_count, out_sat);
        end
        send_beat(pack4(64'd100, 64'd200, 64'd300, 64'd400), 4'hF, 1'b0);
        send_beat(pack4(64'd100, 64'd200, 64'd300, 64'd400), 4'hF, 1'b0);
        clr = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_mid_packet: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        #2 clr = 1'b0;
        @(negedge clk);
        send_beat(pack4(64'd1, 64'd2, 64'd3, 64'd4), 4'hF, 1'b1);
        take_result("after_clr", 64'd10, 4, 0);
        send_beat(pack4(64'd9, 64'd0, 64'd0, 64'd0), 4'hF, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_count !== 16'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_mid_output: out_valid=%b sum=%h count=%0d in_ready=%b expected 0 0 0 1",
                     out_valid, out_sum, out_count, in_ready);
        end
        #2 clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multi_beat;
        for (int b = 0; b < 5; b++) begin
            send_beat({4{64'hFFFF_FFFF_FFFF_FFFF}}, 4'hF, b == 4);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: out_valid=%b expected 0 one cycle after last", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency: out_valid=%b expected 1 two cycles after last", out_valid);
        end
        take_result("multi_beat", 64'hFFFF_FFFF_FFFF_FFEC, 20, 0);
    endtask

    task automatic test_carry_chain;
        send_beat(pack4(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0), 4'hF, 1'b1);
        take_result("carry_chain", 64'h8000_0000_0000_0000, 4, 0);
        send_beat(pack4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0), 4'hF, 1'b1);
        take_result("wrap", 64'd0, 4, 0);
    endtask

    task automatic test_mask_stall;
        send_beat(pack4(64'd10, 64'd20, 64'd30, 64'd40), 4'b0101, 1'b0);
        repeat (3) @(negedge clk);
        send_beat(pack4(64'd77, 64'd88, 64'd99, 64'd11), 4'b0000, 1'b1);
        take_result("mask_stall", 64'd40, 2, 0);
        send_beat(pack4(64'd5, 64'd5, 64'd5, 64'd5), 4'b0000, 1'b1);
        take_result("empty_packet", 64'd0, 0, 0);
    endtask

    task automatic test_backpressure;
        send_beat(pack4(64'd5, 64'd6, 64'd7, 64'd8), 4'hF, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_sum !== 64'd26 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_%0d: out_valid=%b sum=%0d in_ready=%b expected 1 26 0",
                         i, out_valid, out_sum, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 64'd26) begin
            bad++;
            $display("FAIL release: in_ready=%b out_valid=%b sum=%0d expected 1 0 26", in_ready, out_valid, out_sum);
        end
    endtask

    task automatic test_back_to_back;
        send_beat(pack4(64'd1, 64'd1, 64'd1, 64'd1), 4'hF, 1'b1);
        take_result("b2b_first", 64'd4, 4, 0);
        send_beat(pack4(64'd100, 64'd0, 64'd0, 64'd0), 4'b0001, 1'b1);
        take_result("b2b_second", 64'd100, 1, 0);
    endtask

    task automatic test_saturation;
        for (int b = 0; b < 5; b++) begin
            total++;
            if (s_in_ready !== 1'b1) begin
                bad++;
                $display("FAIL sat_ready_%0d: in_ready=%b expected 1", b, s_in_ready);
            end
            s_in_valid = 1'b1;
            s_in_terms = pack4(64'd1, 64'd1, 64'd1, 64'd1);
            s_in_mask  = 4'hF;
            s_in_last  = (b == 4);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        @(negedge clk);
        total++;
        if (s_out_valid !== 1'b1 || s_out_sum !== 64'd20 || s_out_count !== 4'd15 || s_out_sat !== 1'b1) begin
            bad++;
            $display("FAIL saturation: valid=%b sum=%0d count=%0d sat=%b expected 1 20 15 1",
                     s_out_valid, s_out_sum, s_out_count, s_out_sat);
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_last   = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        @(negedge clk);
        total++;
        if (s_out_valid !== 1'b1 || s_out_sum !== 64'd4 || s_out_count !== 4'd4 || s_out_sat !== 1'b0) begin
            bad++;
            $display("FAIL sat_cleared: valid=%b sum=%0d count=%0d sat=%b expected 1 4 4 0",
                     s_out_valid, s_out_sum, s_out_count, s_out_sat);
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    task automatic test_random;
        for (int p = 0; p < 1000; p++) begin
            logic [63:0] exp_sum = 64'd0;
            int          exp_cnt = 0;
            int          beats   = $urandom_range(1, 4);
            for (int b = 0; b < beats; b++) begin
                logic [255:0] t;
                logic [3:0]   m;
                for (int k = 0; k < 4; k++) begin
                    t[k*64 +: 64] = {$urandom, $urandom};
                end
                m = 4'($urandom);
                for (int k = 0; k < 4; k++) begin
                    if (m[k]) begin
                        exp_sum = exp_sum + t[k*64 +: 64];
                        exp_cnt++;
                    end
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat(t, m, b == beats - 1);
            end
            take_result("random", exp_sum, exp_cnt, $urandom_range(0, 2));
        end
    endtask

    initial begin
        clr         = 1'b1;
        in_valid    = 1'b0;
        in_terms    = '0;
        in_mask     = 4'h0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_terms  = '0;
        s_in_mask   = 4'h0;
        s_in_last   = 1'b0;
        s_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        test_reset;
        test_multi_beat;
        test_carry_chain;
        test_mask_stall;
        test_backpressure;
        test_back_to_back;
        test_saturation;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
